// File: rtl/cache_def_pkg.sv
// Shared cache definitions: PLRU defaults and the replacement-unit FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_def_pkg;

    localparam int PLRU_WAYS_DEFAULT = 8;
    localparam int PLRU_SETS_DEFAULT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } plru_state_e;

endpackage

// File: rtl/plru_victim_select.sv
// Combinational victim picker for one PLRU tree: invalid ways first, then tree walk.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the result is always available from the current inputs.
module plru_victim_select
    import cache_def_pkg::*;
#(
    parameter int NUM_WAYS = PLRU_WAYS_DEFAULT,
    localparam int WAY_W = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] tree_i,
    input  logic [NUM_WAYS-1:0] valid_mask_i,
    input  logic [NUM_WAYS-1:0] lock_mask_i,
    output logic [WAY_W-1:0]    way_o,
    output logic                none_o
);

    logic             inv_found;
    int               inv_way;
    int               walk_way;

    // Lowest-indexed way that is both invalid and unlocked.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = 0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_mask_i[w] && !lock_mask_i[w]) begin
                inv_found = 1'b1;
                inv_way   = w;
            end
        end
    end

    // Walk away from the most recent direction; swap to the sibling if the
    // preferred subtree has no unlocked way left.
    always_comb begin
        int   node;
        int   prefix;
        int   dir;
        int   cand;
        int   shift;
        logic all_lk;
        node     = 0;
        prefix   = 0;
        walk_way = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir    = tree_i[node[WAY_W-1:0]] ? 0 : 1;
            cand   = 2 * prefix + dir;
            shift  = WAY_W - 1 - l;
            all_lk = 1'b1;
            for (int w = 0; w < NUM_WAYS; w++) begin
                if ((w >> shift) == cand) begin
                    all_lk = all_lk & lock_mask_i[w];
                end
            end
            if (all_lk) begin
                dir = 1 - dir;
            end
            prefix = 2 * prefix + dir;
            node   = 2 * node + 1 + dir;
        end
        walk_way = prefix;
    end

    // Final priority: fully locked set reports none, then invalid ways, then the walk.
    always_comb begin
        none_o = 1'b0;
        way_o  = '0;
        if (&lock_mask_i) begin
            none_o = 1'b1;
        end else if (inv_found) begin
            way_o = inv_way[WAY_W-1:0];
        end else begin
            way_o = walk_way[WAY_W-1:0];
        end
    end

endmodule

// File: rtl/plru_tree_replacer.sv
// Per-set tree pseudo-LRU: touch updates, registered victim lookup, sequenced flush.
// Latency: victim result 1 cycle after request; flush occupies NUM_SETS cycles.
// Backpressure: none; requests and touches arriving while busy_o is high are dropped.
module plru_tree_replacer
    import cache_def_pkg::*;
#(
    parameter int NUM_WAYS = PLRU_WAYS_DEFAULT,
    parameter int NUM_SETS = PLRU_SETS_DEFAULT,
    localparam int WAY_W = $clog2(NUM_WAYS),
    localparam int SET_W = $clog2(NUM_SETS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                touch_valid_i,
    input  logic [SET_W-1:0]    touch_set_i,
    input  logic [WAY_W-1:0]    touch_way_i,
    input  logic                vic_req_i,
    input  logic [SET_W-1:0]    vic_set_i,
    input  logic [NUM_WAYS-1:0] valid_mask_i,
    input  logic [NUM_WAYS-1:0] lock_mask_i,
    output logic                vic_valid_o,
    output logic [WAY_W-1:0]    vic_way_o,
    output logic                vic_none_o,
    input  logic                flush_i,
    output logic                busy_o
);

    localparam int TREE_W = NUM_WAYS - 1;

    // Set every node on the path to `way` to the matching address bit, MSB at the root.
    function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] tree,
                                                     input logic [WAY_W-1:0]  way);
        logic [TREE_W-1:0] t;
        int                node;
        int                bit_v;
        t    = tree;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            bit_v = (int'(way) >> (WAY_W - 1 - l)) & 1;
            t[node[WAY_W-1:0]] = bit_v[0];
            node = 2 * node + 1 + bit_v;
        end
        return t;
    endfunction

    plru_state_e       state_q, state_d;
    logic [SET_W-1:0]  cnt_q, cnt_d;
    logic [TREE_W-1:0] tree_q [NUM_SETS];
    logic [TREE_W-1:0] tree_d [NUM_SETS];
    logic              vic_valid_q, vic_valid_d;
    logic [WAY_W-1:0]  vic_way_q, vic_way_d;
    logic              vic_none_q, vic_none_d;

    logic              idle;
    logic              touch_en;
    logic              req_en;
    logic [TREE_W-1:0] touched_tree;
    logic [TREE_W-1:0] lookup_tree;
    logic [WAY_W-1:0]  sel_way;
    logic              sel_none;

    // Accept traffic only in IDLE; a same-set touch is forwarded into the lookup.
    always_comb begin
        idle         = (state_q == IDLE);
        touch_en     = idle && touch_valid_i;
        req_en       = idle && vic_req_i;
        touched_tree = plru_touch(tree_q[touch_set_i], touch_way_i);
        if (touch_en && (touch_set_i == vic_set_i)) begin
            lookup_tree = touched_tree;
        end else begin
            lookup_tree = tree_q[vic_set_i];
        end
    end

    plru_victim_select #(
        .NUM_WAYS (NUM_WAYS)
    ) u_victim_select (
        .tree_i       (lookup_tree),
        .valid_mask_i (valid_mask_i),
        .lock_mask_i  (lock_mask_i),
        .way_o        (sel_way),
        .none_o       (sel_none)
    );

    // Next-state for the flush sequencer and tree storage.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tree_d  = tree_q;
        if (touch_en) begin
            tree_d[touch_set_i] = touched_tree;
        end
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                tree_d[cnt_q] = '0;
                if (cnt_q == SET_W'(NUM_SETS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Victim result: pulse valid, hold way/none between requests.
    always_comb begin
        vic_valid_d = req_en;
        vic_way_d   = vic_way_q;
        vic_none_d  = vic_none_q;
        if (req_en) begin
            vic_way_d  = sel_way;
            vic_none_d = sel_none;
        end
    end

    // State registers; reset clears every tree and aborts any flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vic_valid_q <= 1'b0;
            vic_way_q   <= '0;
            vic_none_q  <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                tree_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vic_valid_q <= vic_valid_d;
            vic_way_q   <= vic_way_d;
            vic_none_q  <= vic_none_d;
            for (int s = 0; s < NUM_SETS; s++) begin
                tree_q[s] <= tree_d[s];
            end
        end
    end

    assign vic_valid_o = vic_valid_q;
    assign vic_way_o   = vic_way_q;
    assign vic_none_o  = vic_none_q;
    assign busy_o      = (state_q == FLUSH);

endmodule
